// File: rtl/core_pkg.sv
// core_pkg: shared core-wide sizing and instruction ID type
package core_pkg;
  localparam int NrVFU = 3;
  localparam int InsnIDNum = 8;
  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
endpackage

// File: rtl/vcommit_sequencer_if.sv
// vcommit_sequencer_if: launcher, VFU done and scalar-core retire signals of the commit sequencer
interface vcommit_sequencer_if
  import core_pkg::*;
#(
  parameter int NrVFU = core_pkg::NrVFU
);
  logic alloc_valid_i;
  logic alloc_ready_o;
  insn_id_t alloc_id_i;
  logic [NrVFU-1:0] vfu_done_i;
  insn_id_t [NrVFU-1:0] vfu_done_id_i;
  logic flush_i;
  logic done_o;
  insn_id_t done_insn_id_o;
  logic done_ready_i;
  logic spurious_o;
  modport master (
    output alloc_valid_i, alloc_id_i, vfu_done_i, vfu_done_id_i, flush_i, done_ready_i,
    input  alloc_ready_o, done_o, done_insn_id_o, spurious_o
  );
  modport slave (
    input  alloc_valid_i, alloc_id_i, vfu_done_i, vfu_done_id_i, flush_i, done_ready_i,
    output alloc_ready_o, done_o, done_insn_id_o, spurious_o
  );
endinterface

// File: rtl/vcommit_sequencer_id_fifo.sv
// id_fifo: program-order ID queue with wrap-bit pointers; flush empties it, reset also clears storage
module id_fifo #(
  parameter int Depth = 8,
  parameter int Width = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [Width-1:0] push_data,
  output logic full,
  output logic empty,
  output logic [Width-1:0] head
);
  localparam int Aw = $clog2(Depth);
  logic [Aw:0] wr_ptr, rd_ptr;
  logic [Depth-1:0][Width-1:0] mem;
  assign full = (wr_ptr[Aw-1:0] == rd_ptr[Aw-1:0]) && (wr_ptr[Aw] != rd_ptr[Aw]);
  assign empty = wr_ptr == rd_ptr;
  assign head = mem[rd_ptr[Aw-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[Aw-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/vcommit_sequencer.sv
// vcommit_sequencer: retires out-of-order VFU completions in issue order; VCOMMIT_BYPASS_EN adds same-cycle head completion
module vcommit_sequencer
  import core_pkg::*;
#(
  parameter int NrVFU = core_pkg::NrVFU,
  parameter int InsnIDNum = core_pkg::InsnIDNum
) (
  input logic clk_i,
  input logic rst_i,
  vcommit_sequencer_if.slave bus
);
  logic [InsnIDNum-1:0] inflight, inflight_d, done_bits, done_bits_d;
  logic spurious, spurious_d;
  logic full, empty, push, pop, head_hit;
  insn_id_t head_id;
  id_fifo #(.Depth(InsnIDNum), .Width($bits(insn_id_t))) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .flush(bus.flush_i),
    .push(push),
    .pop(pop),
    .push_data(bus.alloc_id_i),
    .full(full),
    .empty(empty),
    .head(head_id)
  );
`ifdef VCOMMIT_BYPASS_EN
  always_comb begin
    head_hit = 1'b0;
    for (int k = 0; k < NrVFU; k++)
      head_hit = head_hit | (bus.vfu_done_i[k] && bus.vfu_done_id_i[k] == head_id && inflight[head_id]);
  end
`else
  assign head_hit = 1'b0;
`endif
  assign bus.done_o = !rst_i && !bus.flush_i && !empty && (done_bits[head_id] || head_hit);
  assign bus.done_insn_id_o = rst_i ? '0 : head_id;
  assign bus.alloc_ready_o = rst_i || !full;
  assign bus.spurious_o = spurious && !rst_i;
  assign pop = bus.done_o && bus.done_ready_i;
  // a retire in the same cycle frees the slot, so a full queue still takes the push
  assign push = bus.alloc_valid_i && (!full || pop);
  always_comb begin
    inflight_d = inflight;
    done_bits_d = done_bits;
    spurious_d = spurious;
    for (int k = 0; k < NrVFU; k++)
      if (bus.vfu_done_i[k]) begin
        if (inflight[bus.vfu_done_id_i[k]]) done_bits_d[bus.vfu_done_id_i[k]] = 1'b1;
        else spurious_d = 1'b1;
      end
    if (pop) begin
      inflight_d[head_id] = 1'b0;
      done_bits_d[head_id] = 1'b0;
    end
    if (push) begin
      inflight_d[bus.alloc_id_i] = 1'b1;
      done_bits_d[bus.alloc_id_i] = 1'b0;
    end
    if (bus.flush_i) begin
      inflight_d = '0;
      done_bits_d = '0;
      spurious_d = spurious;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= '0;
      done_bits <= '0;
      spurious <= 1'b0;
    end else begin
      inflight <= inflight_d;
      done_bits <= done_bits_d;
      spurious <= spurious_d;
    end
  end
endmodule

// File: tb/tb_vcommit_sequencer.sv
// tb_vcommit_sequencer: directed scenarios plus random traffic checked against a queue-based model
module tb_vcommit_sequencer;
  import core_pkg::*;
  localparam int N = InsnIDNum;
  localparam int V = NrVFU;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vcommit_sequencer_if #(.NrVFU(V)) bus ();
  vcommit_sequencer #(.NrVFU(V), .InsnIDNum(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int q[$];
  bit done_m[N];
  bit spur_m = 1'b0;
  int obs[$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic bit in_q(int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction
  task automatic idle();
    bus.alloc_valid_i = 1'b0;
    bus.alloc_id_i = '0;
    bus.vfu_done_i = '0;
    bus.vfu_done_id_i = '0;
    bus.flush_i = 1'b0;
    bus.done_ready_i = 1'b1;
  endtask
  task automatic cycle();
    bit hit, exp_done, retire, push;
    int sz;
    @(negedge clk);
    sz = q.size();
    hit = 1'b0;
`ifdef VCOMMIT_BYPASS_EN
    for (int k = 0; k < V; k++)
      if (bus.vfu_done_i[k] && sz > 0 && int'(bus.vfu_done_id_i[k]) == q[0]) hit = 1'b1;
`endif
    exp_done = !rst && !bus.flush_i && sz > 0 && (done_m[q[0]] || hit);
    check("alloc_ready", bus.alloc_ready_o, rst || sz < N);
    check("done_o", bus.done_o, exp_done);
    if (rst) check("done_id_rst", bus.done_insn_id_o, 0);
    else if (sz > 0) check("done_id", bus.done_insn_id_o, q[0]);
    check("spurious", bus.spurious_o, rst ? 1'b0 : spur_m);
    if (bus.done_o && bus.done_ready_i) obs.push_back(int'(bus.done_insn_id_o));
    retire = exp_done && bus.done_ready_i;
    if (rst) begin
      q.delete();
      done_m = '{default: 1'b0};
      spur_m = 1'b0;
    end else if (bus.flush_i) begin
      q.delete();
      done_m = '{default: 1'b0};
    end else begin
      for (int k = 0; k < V; k++)
        if (bus.vfu_done_i[k]) begin
          if (in_q(int'(bus.vfu_done_id_i[k]))) done_m[bus.vfu_done_id_i[k]] = 1'b1;
          else spur_m = 1'b1;
        end
      push = bus.alloc_valid_i && (sz < N || retire);
      if (retire) begin
        done_m[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (push) begin
        done_m[bus.alloc_id_i] = 1'b0;
        q.push_back(int'(bus.alloc_id_i));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(int id);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_id_i = insn_id_t'(id);
    cycle();
    bus.alloc_valid_i = 1'b0;
  endtask
  task automatic vdone(int k, int id);
    bus.vfu_done_i[k] = 1'b1;
    bus.vfu_done_id_i[k] = insn_id_t'(id);
    cycle();
    bus.vfu_done_i = '0;
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && q.size() > 0; n++) begin
      bus.vfu_done_i[0] = 1'b1;
      bus.vfu_done_id_i[0] = insn_id_t'(q[$urandom_range(q.size() - 1)]);
      cycle();
    end
    idle();
    cycle();
  endtask
  initial begin
    int free_ids[$];
    idle();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();
    // in-order retirement of out-of-order completions
    obs.delete();
    alloc(3); alloc(5); alloc(1);
    vdone(0, 1); vdone(0, 5); vdone(0, 3);
    check("order_early", obs.size(), 0);
    cycle();
    check("first_n", obs.size(), 1);
    check("first_id", obs.size() > 0 ? obs[0] : -1, 3);
    cycle(); cycle();
    check("order_n", obs.size(), 3);
    if (obs.size() == 3) begin
      check("order_1", obs[1], 5);
      check("order_2", obs[2], 1);
    end
    // full queue with simultaneous retire and push
    for (int i = 0; i < N; i++) alloc(i);
    check("full_ready", bus.alloc_ready_o, 0);
    vdone(0, 0);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_id_i = '0;
    cycle();
    bus.alloc_valid_i = 1'b0;
    check("full_after_swap", bus.alloc_ready_o, 0);
    check("tail_not_done", bus.done_o, 0);
    drain();
    // duplicate done from two VFUs
    obs.delete();
    alloc(4);
    bus.vfu_done_i[0] = 1'b1; bus.vfu_done_id_i[0] = insn_id_t'(4);
    bus.vfu_done_i[V-1] = 1'b1; bus.vfu_done_id_i[V-1] = insn_id_t'(4);
    cycle();
    idle();
    cycle(); cycle();
    check("dup_n", obs.size(), 1);
    check("dup_id", obs.size() > 0 ? obs[0] : -1, 4);
    check("dup_spur", bus.spurious_o, 0);
    // backpressure
    obs.delete();
    alloc(2);
    vdone(0, 2);
    bus.done_ready_i = 1'b0;
    repeat (3) cycle();
    check("bp_hold_n", obs.size(), 0);
    bus.done_ready_i = 1'b1;
    cycle();
    check("bp_accept_n", obs.size(), 1);
    // spurious done
    alloc(7);
    vdone(1, 6);
    check("spur_set", bus.spurious_o, 1);
    check("spur_queue_head", bus.done_insn_id_o, 7);
    cycle();
    // flush mid-queue, spurious must survive
    alloc(1); alloc(2); alloc(3);
    bus.done_ready_i = 1'b0;
    bus.vfu_done_i[0] = 1'b1; bus.vfu_done_id_i[0] = insn_id_t'(7);
    bus.vfu_done_i[1] = 1'b1; bus.vfu_done_id_i[1] = insn_id_t'(2);
    cycle();
    bus.vfu_done_i = '0;
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    check("flush_done", bus.done_o, 0);
    check("flush_ready", bus.alloc_ready_o, 1);
    check("flush_spur", bus.spurious_o, 1);
    cycle();
    // reset mid-queue
    alloc(1); alloc(2); alloc(3); alloc(5);
    bus.vfu_done_i[0] = 1'b1; bus.vfu_done_id_i[0] = insn_id_t'(1);
    bus.vfu_done_i[1] = 1'b1; bus.vfu_done_id_i[1] = insn_id_t'(3);
    cycle();
    bus.vfu_done_i = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_done", bus.done_o, 0);
    check("rst_ready", bus.alloc_ready_o, 1);
    check("rst_spur", bus.spurious_o, 0);
    check("rst_id", bus.done_insn_id_o, 0);
    idle();
    cycle();
    // random traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      bus.flush_i = $urandom_range(99) == 0;
      bus.done_ready_i = $urandom_range(9) < 7;
      free_ids.delete();
      for (int i = 0; i < N; i++) if (!in_q(i)) free_ids.push_back(i);
      if (free_ids.size() > 0 && $urandom_range(1) == 1) begin
        bus.alloc_valid_i = 1'b1;
        bus.alloc_id_i = insn_id_t'(free_ids[$urandom_range(free_ids.size() - 1)]);
      end
      for (int k = 0; k < V; k++) begin
        bus.vfu_done_i[k] = $urandom_range(9) < 3;
        if (q.size() > 0 && $urandom_range(19) != 0)
          bus.vfu_done_id_i[k] = insn_id_t'(q[$urandom_range(q.size() - 1)]);
        else
          bus.vfu_done_id_i[k] = insn_id_t'($urandom_range(N - 1));
      end
      cycle();
    end
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
